// File: rtl/shift_right_iter_if.sv
// Handshake and data bundle between the control unit and the iterative right shifter.
// The control unit takes the master side and the shifter takes the slave side.
interface shift_right_iter_if #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;

  modport master (
    output start, data_in, shamt, arith,
    input  result, busy, done
  );

  modport slave (
    input  start, data_in, shamt, arith,
    output result, busy, done
  );
endinterface

// File: rtl/shift_right_iter.sv
// Multi-cycle SRL/SRA unit: shifts the captured operand right by one bit per clock.
// The unit is driven by a start/busy/done handshake and holds the result until the next start.
module shift_right_iter #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input logic              clk,
  input logic              reset,
  shift_right_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] count_q;
  logic               fill_mode_q;

  // NOTE: every register in this block uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      result_q    <= '0;
      count_q     <= '0;
      fill_mode_q <= 1'b0;
    end else begin
      unique case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
        IDLE, DONE: begin
          if (bus.start) begin
            result_q    <= bus.data_in;
            count_q     <= bus.shamt;
            fill_mode_q <= bus.arith;
            state       <= (bus.shamt == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          result_q <= {fill_mode_q & result_q[WIDTH-1], result_q[WIDTH-1:1]};
          count_q  <= count_q - 1'b1;
          if (count_q == SHAMT_W'(1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed bench for shift_right_iter: latency, fill modes, start masking, reset abort and back-to-back starts.
// All inputs are driven and all outputs sampled 1 time unit after the rising edge.
module tb_shift_right_iter;
  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 6;
  localparam int LIMIT   = 200;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  shift_right_iter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_right_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one start over the next edge; afterwards the operand inputs are scrambled
  // so that only the captured copies can produce the expected result.
  task automatic launch(input logic [WIDTH-1:0] data, input logic [SHAMT_W-1:0] sh,
                        input logic ar, input bit keep_start);
    bus.data_in = data;
    bus.shamt   = sh;
    bus.arith   = ar;
    bus.start   = 1'b1;
    tick();
    bus.start   = keep_start;
    if (!keep_start) begin
      bus.data_in = ~data;
      bus.shamt   = SHAMT_W'($urandom_range(0, WIDTH - 1));
      bus.arith   = ~ar;
    end
  endtask

  // Called in cycle n0 after the start cycle; waits (bounded) for done and checks
  // latency, busy during the shift and the final result.
  task automatic wait_done(input string tag, input int n0, input int exp_cycles,
                           input logic [WIDTH-1:0] exp_result);
    int n;
    bit busy_ok;
    n       = n0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n <= LIMIT) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, WIDTH'(n), WIDTH'(exp_cycles));
    check({tag, "_busy_in_shift"}, WIDTH'(busy_ok), WIDTH'(1));
    check({tag, "_busy_at_done"}, WIDTH'(bus.busy), WIDTH'(0));
    check({tag, "_result"}, bus.result, exp_result);
  endtask

  initial begin
    bit done_seen;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.arith   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_result", bus.result, 64'h0);
    check("reset_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("reset_done", WIDTH'(bus.done), WIDTH'(0));
    tick();

    // Basic logical shift; done lasts one cycle and the result is then held in IDLE.
    launch(64'hF0, 6'd4, 1'b0, 1'b0);
    wait_done("srl4", 1, 5, 64'h0F);
    tick();
    check("srl4_done_pulse", WIDTH'(bus.done), WIDTH'(0));
    check("srl4_hold", bus.result, 64'h0F);

    // Full-width shifts of the MSB.
    launch(64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0);
    wait_done("sra63", 1, 64, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    launch(64'h8000_0000_0000_0000, 6'd63, 1'b0, 1'b0);
    wait_done("srl63", 1, 64, 64'h1);
    tick();

    // Sign fill versus zero fill on the same pattern.
    launch(64'hF000_0000_0000_00F0, 6'd4, 1'b1, 1'b0);
    wait_done("sra4_neg", 1, 5, 64'hFF00_0000_0000_000F);
    tick();
    launch(64'hF000_0000_0000_00F0, 6'd4, 1'b0, 1'b0);
    wait_done("srl4_neg", 1, 5, 64'h0F00_0000_0000_000F);
    tick();
    launch(64'h7000_0000_0000_0000, 6'd4, 1'b1, 1'b0);
    wait_done("sra4_pos", 1, 5, 64'h0700_0000_0000_0000);
    tick();

    // Zero shift amount goes straight to DONE.
    launch(64'h1234, 6'd0, 1'b0, 1'b0);
    wait_done("shamt0", 1, 1, 64'h1234);
    tick();

    // A start pulse in the middle of SHIFT is ignored.
    launch(64'hF000, 6'd8, 1'b0, 1'b0);
    tick();
    tick();
    bus.data_in = 64'hFFFF;
    bus.shamt   = 6'd2;
    bus.arith   = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    wait_done("mid_start", 4, 9, 64'hF0);
    tick();

    // Reset while count==10 aborts the operation with no done pulse.
    launch(64'hDEAD_BEEF_0000_0001, 6'd20, 1'b1, 1'b0);
    repeat (10) tick();
    check("pre_abort_busy", WIDTH'(bus.busy), WIDTH'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_result", bus.result, 64'h0);
    check("abort_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("abort_done", WIDTH'(bus.done), WIDTH'(0));
    done_seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", WIDTH'(done_seen), WIDTH'(0));

    // Start held high through SHIFT and DONE: the DONE cycle accepts the next operation.
    launch(64'h1234_5678, 6'd3, 1'b0, 1'b1);
    wait_done("b2b_first", 1, 4, 64'h0246_8ACF);
    bus.data_in = 64'hFF;
    bus.shamt   = 6'd8;
    bus.arith   = 1'b0;
    tick();
    bus.start   = 1'b0;
    check("b2b_accept_busy", WIDTH'(bus.busy), WIDTH'(1));
    wait_done("b2b_second", 1, 9, 64'h0);
    tick();
    check("b2b_idle_done", WIDTH'(bus.done), WIDTH'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
